// File: rtl/led_pwm_ctrl.sv
// Multi-channel LED driver with off/on/blink/PWM modes. A single pending
// configuration slot is committed only on PWM period boundaries.
module led_pwm_ctrl #(
  parameter int unsigned N_CH           = 4,
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned BLINK_BIT      = 24,
  parameter int unsigned PWM_W          = 8,
  parameter int unsigned PWM_DIV        = 98,
  parameter bit          LED_ACTIVE_LOW = 1'b0
) (
  input  logic             clk25,
  input  logic             fpga_rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [3:0]       cfg_ch,
  input  logic [1:0]       cfg_mode,
  input  logic [PWM_W-1:0] cfg_duty,
  output logic             cfg_err,
  output logic             busy,
  output logic [N_CH-1:0]  led_out
);

  localparam int unsigned      PRE_W    = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PWM_DIV - 1);
  localparam logic [4:0]       N_CH_L   = 5'(N_CH);
  localparam logic [N_CH-1:0]  POL      = {N_CH{LED_ACTIVE_LOW}};

  localparam logic [1:0] MODE_OFF   = 2'b00;
  localparam logic [1:0] MODE_ON    = 2'b01;
  localparam logic [1:0] MODE_BLINK = 2'b10;
  localparam logic [1:0] MODE_PWM   = 2'b11;

  logic [CNT_W-1:0] led_cnt;
  logic [PRE_W-1:0] presc;
  logic [PWM_W-1:0] pwm_cnt;
  logic             tick;
  logic             boundary;
  logic             xfer;
  logic             ch_ok;

  logic             pend_vld;
  logic [3:0]       pend_ch;
  logic [1:0]       pend_mode;
  logic [PWM_W-1:0] pend_duty;

  logic [1:0]       act_mode [N_CH];
  logic [PWM_W-1:0] act_duty [N_CH];
  logic [N_CH-1:0]  raw;

  assign tick      = (presc == PRE_LAST);
  assign boundary  = tick && (pwm_cnt == '1);
  assign cfg_ready = !pend_vld;
  assign busy      = pend_vld;
  assign xfer      = cfg_valid && cfg_ready;
  assign ch_ok     = ({1'b0, cfg_ch} < N_CH_L);

  always_ff @(posedge clk25 or negedge fpga_rst_n) begin
    if (!fpga_rst_n) begin
      led_cnt <= '0;
      presc   <= '0;
      pwm_cnt <= '0;
    end else begin
      led_cnt <= led_cnt + 1'b1;
      presc   <= tick ? '0 : presc + 1'b1;
      if (tick)
        pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

  // Pending slot is set the cycle after the transfer, so a boundary that
  // coincides with the transfer itself can never commit it.
  always_ff @(posedge clk25 or negedge fpga_rst_n) begin
    if (!fpga_rst_n) begin
      pend_vld  <= 1'b0;
      pend_ch   <= '0;
      pend_mode <= '0;
      pend_duty <= '0;
      cfg_err   <= 1'b0;
      for (int unsigned i = 0; i < N_CH; i++) begin
        act_mode[i] <= MODE_OFF;
        act_duty[i] <= '0;
      end
    end else begin
      cfg_err <= xfer && !ch_ok;
      if (pend_vld && boundary) begin
        pend_vld <= 1'b0;
        for (int unsigned i = 0; i < N_CH; i++) begin
          if (pend_ch == 4'(i)) begin
            act_mode[i] <= pend_mode;
            act_duty[i] <= pend_duty;
          end
        end
      end else if (xfer && ch_ok) begin
        pend_vld  <= 1'b1;
        pend_ch   <= cfg_ch;
        pend_mode <= cfg_mode;
        pend_duty <= cfg_duty;
      end
    end
  end

  always_comb begin
    raw = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      case (act_mode[i])
        MODE_OFF:   raw[i] = 1'b0;
        MODE_ON:    raw[i] = 1'b1;
        MODE_BLINK: raw[i] = led_cnt[BLINK_BIT];
        MODE_PWM:   raw[i] = (pwm_cnt < act_duty[i]);
        default:    raw[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk25 or negedge fpga_rst_n) begin
    if (!fpga_rst_n)
      led_out <= POL;
    else
      led_out <= raw ^ POL;
  end

endmodule

// File: tb/tb_led_pwm_ctrl.sv
// Randomized bench for led_pwm_ctrl: a cycle-index reference model predicts
// handshake, commit timing and LED levels for active-high and active-low copies.
module tb_led_pwm_ctrl;

  localparam int unsigned N_CH      = 4;
  localparam int unsigned PWM_W     = 4;
  localparam int unsigned PWM_DIV   = 1;
  localparam int unsigned BLINK_BIT = 3;
  localparam int unsigned STEPS     = 1 << PWM_W;
  localparam int unsigned PERIOD    = STEPS * PWM_DIV;

  logic             clk25      = 1'b0;
  logic             fpga_rst_n = 1'b0;
  logic             cfg_valid  = 1'b0;
  logic [3:0]       cfg_ch     = '0;
  logic [1:0]       cfg_mode   = '0;
  logic [PWM_W-1:0] cfg_duty   = '0;
  logic             cfg_ready, cfg_err, busy;
  logic [N_CH-1:0]  led_out;
  logic             cfg_ready_al, cfg_err_al, busy_al;
  logic [N_CH-1:0]  led_out_al;

  always #5 clk25 = ~clk25;

  led_pwm_ctrl #(
    .N_CH(N_CH), .CNT_W(32), .BLINK_BIT(BLINK_BIT), .PWM_W(PWM_W),
    .PWM_DIV(PWM_DIV), .LED_ACTIVE_LOW(1'b0)
  ) dut (
    .clk25(clk25), .fpga_rst_n(fpga_rst_n), .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
    .cfg_duty(cfg_duty), .cfg_err(cfg_err), .busy(busy), .led_out(led_out)
  );

  led_pwm_ctrl #(
    .N_CH(N_CH), .CNT_W(32), .BLINK_BIT(BLINK_BIT), .PWM_W(PWM_W),
    .PWM_DIV(PWM_DIV), .LED_ACTIVE_LOW(1'b1)
  ) dut_al (
    .clk25(clk25), .fpga_rst_n(fpga_rst_n), .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready_al), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
    .cfg_duty(cfg_duty), .cfg_err(cfg_err_al), .busy(busy_al), .led_out(led_out_al)
  );

  // Reference state: k is the number of clock edges since reset release.
  int unsigned     k;
  bit              m_busy;
  bit              m_err;
  bit              m_acc;
  int unsigned     commit_at;
  int unsigned     p_ch, p_mode, p_duty;
  int unsigned     m_mode [N_CH];
  int unsigned     m_duty [N_CH];
  logic [N_CH-1:0] m_led;
  bit              rst_req;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, k);
    end
  endtask

  function automatic bit raw_level(input int unsigned ch);
    case (m_mode[ch])
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return ((k >> BLINK_BIT) & 1) == 1;
      default: return ((k / PWM_DIV) % STEPS) < m_duty[ch];
    endcase
  endfunction

  task automatic model_reset();
    k = 0; m_busy = 0; m_err = 0; m_acc = 0; commit_at = 0; m_led = '0;
    for (int i = 0; i < N_CH; i++) begin
      m_mode[i] = 0;
      m_duty[i] = 0;
    end
  endtask

  task automatic model_step();
    logic [N_CH-1:0] n_led;
    bit xfer;
    for (int i = 0; i < N_CH; i++) n_led[i] = raw_level(i);
    xfer  = cfg_valid && !m_busy;
    m_err = xfer && (cfg_ch >= N_CH);
    m_acc = 0;
    if (m_busy && k == commit_at) begin
      m_mode[p_ch] = p_mode;
      m_duty[p_ch] = p_duty;
      m_busy = 0;
    end else if (xfer && cfg_ch < N_CH) begin
      p_ch = cfg_ch; p_mode = cfg_mode; p_duty = cfg_duty;
      commit_at = (k / PERIOD) * PERIOD + PERIOD - 1;
      if (commit_at == k) commit_at += PERIOD;
      m_busy = 1;
      m_acc  = 1;
    end
    m_led = n_led;
    k++;
  endtask

  task automatic check_outputs();
    logic [N_CH-1:0] exp_al;
    exp_al = m_led ^ {N_CH{1'b1}};
    check_eq("cfg_ready", cfg_ready, !m_busy);
    check_eq("busy", busy, m_busy);
    check_eq("cfg_err", cfg_err, m_err);
    check_eq("led_out", led_out, m_led);
    check_eq("led_out_al", led_out_al, exp_al);
    check_eq("busy_al", busy_al, m_busy);
    check_eq("led_cnt", dut.led_cnt, k);
  endtask

  task automatic cycle(input bit v, input logic [3:0] ch, input logic [1:0] md,
                       input logic [PWM_W-1:0] dt);
    @(negedge clk25);
    check_outputs();
    fpga_rst_n = !rst_req;
    cfg_valid  = v;
    cfg_ch     = ch;
    cfg_mode   = md;
    cfg_duty   = dt;
    if (fpga_rst_n) model_step();
    else            model_reset();
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 4'($urandom), 2'($urandom), PWM_W'($urandom));
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (m_busy && guard < 4 * PERIOD) begin
      idle(1);
      guard++;
    end
    if (m_busy) check_eq("idle_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    logic [3:0]       rch;
    logic [1:0]       rmd;
    logic [PWM_W-1:0] rdt;
    int               stage;
    int               guard;

    model_reset();
    rst_req = 1;
    idle(3);
    rst_req = 0;
    idle(20);

    // Channel 1 PWM at duty 4, then channel 2 blink
    cycle(1'b1, 4'd1, 2'b11, 4'd4);
    wait_idle();
    idle(40);
    cycle(1'b1, 4'd2, 2'b10, 4'd0);
    wait_idle();
    idle(40);

    // Out-of-range channel raises a single-cycle error only
    cycle(1'b1, 4'd7, 2'b01, 4'd9);
    idle(5);

    // Two requests with cfg_valid held high throughout
    stage = 0;
    guard = 0;
    while (stage < 2 && guard < 200) begin
      if (stage == 0) cycle(1'b1, 4'd0, 2'b01, 4'd0);
      else            cycle(1'b1, 4'd3, 2'b11, 4'd15);
      if (m_acc) stage++;
      guard++;
    end
    if (stage < 2) check_eq("b2b_timeout", 32'd1, 32'd0);
    wait_idle();
    idle(34);

    // Randomized traffic, including invalid channels and extreme duties
    for (int n = 0; n < 800; n++) begin
      rch = 4'($urandom_range(0, 7));
      rmd = 2'($urandom);
      case ($urandom_range(0, 3))
        0:       rdt = '0;
        1:       rdt = '1;
        default: rdt = PWM_W'($urandom);
      endcase
      cycle($urandom_range(0, 2) == 0, rch, rmd, rdt);
    end
    wait_idle();
    idle(20);

    // Reset while an update is pending must discard it
    cycle(1'b1, 4'd2, 2'b11, 4'd9);
    idle(2);
    rst_req = 1;
    idle(3);
    rst_req = 0;
    idle(40);

    // Transfer presented on the very edge that follows reset release
    rst_req = 1;
    idle(2);
    rst_req = 0;
    cycle(1'b1, 4'd1, 2'b01, 4'd0);
    wait_idle();
    idle(10);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/led_pwm_ctrl.md
LED_PWM_CTRL -- requirements
Module: led_pwm_ctrl

Parameters
REQ-001 N_CH, 4, number of LED channels (1..16).
REQ-002 CNT_W, 32, width of the free-running blink counter.
REQ-003 BLINK_BIT, 24, counter bit driving blink mode (< CNT_W).
REQ-004 PWM_W, 8, PWM counter and duty width.
REQ-005 PWM_DIV, 98, clk25 cycles per PWM step (>= 1).
REQ-006 LED_ACTIVE_LOW, 0, when 1 every led_out bit is inverted.

Interface
REQ-007 clk25  input  1  sole clock; all state on rising edge.
REQ-008 fpga_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-009 cfg_valid  input  1  configuration request.
REQ-010 cfg_ready  output  1  block can accept a request.
REQ-011 cfg_ch  input  4  target channel index.
REQ-012 cfg_mode  input  2  00 off, 01 on, 10 blink, 11 PWM.
REQ-013 cfg_duty  input  PWM_W  PWM duty for mode 11.
REQ-014 cfg_err  output  1  one-cycle pulse: accepted request had cfg_ch >= N_CH.
REQ-015 busy  output  1  an update is pending.
REQ-016 led_out  output  N_CH  registered LED drive.

Function
REQ-017 led_cnt (CNT_W bits) shall increment by 1 every cycle and wrap from all-ones to 0.
REQ-018 Prescaler shall count 0..PWM_DIV-1 and wrap; tick = prescaler at PWM_DIV-1.
REQ-019 pwm_cnt (PWM_W bits) shall increment on tick only and wrap from 2^PWM_W-1 to 0.
REQ-020 Period boundary = tick while pwm_cnt = 2^PWM_W-1.
REQ-021 Handshake: a transfer occurs on a cycle with cfg_valid = 1 and cfg_ready = 1; cfg_* are sampled on that cycle only.
REQ-022 A valid transfer (cfg_ch < N_CH) shall load the pending register; cfg_ready = 0 and busy = 1 from the next cycle.
REQ-023 The pending entry shall commit to the channel's active mode/duty on the first period boundary strictly after the transfer cycle, including when the transfer cycle is itself a boundary.
REQ-024 On the cycle after commit, busy = 0 and cfg_ready = 1.
REQ-025 A transfer with cfg_ch >= N_CH shall not change any state except cfg_err = 1 on the next cycle; cfg_ready stays 1.
REQ-026 Channel raw level: mode 00 -> 0; 01 -> 1; 10 -> led_cnt[BLINK_BIT]; 11 -> (pwm_cnt < duty).
REQ-027 PWM duty 0 gives a constant 0; duty 2^PWM_W-1 gives a high level for 2^PWM_W-1 of 2^PWM_W steps.
REQ-028 led_out[i] = raw level XOR LED_ACTIVE_LOW, registered; 1-cycle latency from counter/active state to pin.
REQ-029 Active mode/duty shall change only at period boundaries, so no PWM period is truncated.
REQ-030 Channel count, widths and the compare shall be sized from the parameters; no fixed widths except cfg_ch and cfg_mode.

Reset
REQ-031 While fpga_rst_n = 0: led_cnt, prescaler and pwm_cnt = 0; all active modes = 00, duties = 0; pending cleared.
REQ-032 Reset outputs: cfg_ready = 1, busy = 0, cfg_err = 0, led_out = all LED_ACTIVE_LOW.
REQ-033 Reset asserted mid-update shall discard the pending entry; no commit after release.
REQ-034 First transfer is accepted on the first rising edge after release.

Verification (bench params N_CH=4, PWM_W=4, PWM_DIV=1, BLINK_BIT=3, LED_ACTIVE_LOW=0)
REQ-035 Reset release, no config -> led_out = 4'b0000 forever; cfg_ready = 1; led_cnt reaches 16 after 16 cycles.
REQ-036 Transfer ch=1 mode=11 duty=4 -> busy = 1 until the next boundary; thereafter led_out[1] high 4 of every 16 cycles, in phase with pwm_cnt 0..3.
REQ-037 Transfer ch=2 mode=10 -> after commit led_out[2] toggles every 8 cycles, matching led_cnt[3] delayed 1 cycle.
REQ-038 Transfer ch=7 -> cfg_err pulses exactly 1 cycle, busy stays 0, led_out unchanged.
REQ-039 cfg_valid held high with 2 back-to-back requests -> second accepted only the cycle after the first commits; each commits on its own boundary.
REQ-040 Reset pulse while busy = 1 -> after release all channels off, busy = 0, no late commit; repeat with LED_ACTIVE_LOW=1 -> led_out = 4'b1111.
